// File: rtl/uart_row_tx.sv
// Purpose: 8N1 UART transmitter that dumps one 16-character row (plus optional CR/LF) on request.
// Latency: first start bit FETCH_WAIT+1 clocks after start; each character costs FETCH_WAIT+10*DELAY_FRAMES+1 clocks.
// Backpressure: none; start is only sampled in IDLE, and requests made while busy are dropped, not queued.
//
// Ports:
//   clk       system clock
//   resetN    asynchronous active-low reset; abandons any dump, line returns high at once
//   start     request a row dump (sampled only when idle)
//   charByte  byte returned by the row block for charIndex (registered or combinational row)
//   charIndex character index presented to the row block; stable for a whole character
//   uartTx    serial line, registered, idles high
//   busy      high from the cycle after an accepted start until the done cycle
//   done      one-cycle pulse after the final stop bit
`timescale 1ns/1ps
module uart_row_tx #(
   parameter int DELAY_FRAMES = 234,
   parameter int FETCH_WAIT   = 2,
   parameter int APPEND_CRLF  = 1
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       start,
   input  logic [7:0] charByte,
   output logic [3:0] charIndex,
   output logic       uartTx,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_START_BIT,
      S_DATA_BITS,
      S_STOP_BIT,
      S_NEXT
   } state_t;

   // Which byte source the current character comes from.
   typedef enum logic [1:0] {
      PH_CHAR,
      PH_CR,
      PH_LF
   } phase_t;

   localparam logic [15:0] BAUD_LAST  = 16'(DELAY_FRAMES - 1);
   localparam logic [3:0]  FETCH_LAST = 4'(FETCH_WAIT - 1);
   localparam logic        CRLF_EN    = (APPEND_CRLF != 0);

   state_t      state, state_d;
   phase_t      phase, phase_d;
   logic [3:0]  fetch_cnt, fetch_cnt_d;
   logic [15:0] baud_cnt, baud_cnt_d;
   logic [2:0]  bit_cnt, bit_cnt_d;
   logic [7:0]  shreg, shreg_d;
   logic [3:0]  index_d;
   logic        tx_d, busy_d, done_d;
   logic [7:0]  fetch_byte;
   logic        baud_last;

   assign baud_last = (baud_cnt == BAUD_LAST);

   // Terminator bytes replace the row data during the CR/LF phases.
   always_comb begin
      fetch_byte = charByte;
      case (phase)
         PH_CR:   fetch_byte = 8'd13;
         PH_LF:   fetch_byte = 8'd10;
         default: fetch_byte = charByte;
      endcase
   end

   // Next-state and next-output logic. uartTx is computed one cycle ahead
   // so the registered line changes exactly when the state does.
   always_comb begin
      state_d     = state;
      phase_d     = phase;
      fetch_cnt_d = fetch_cnt;
      baud_cnt_d  = baud_cnt;
      bit_cnt_d   = bit_cnt;
      shreg_d     = shreg;
      index_d     = charIndex;
      tx_d        = 1'b1;
      busy_d      = busy;
      done_d      = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               index_d     = 4'd0;
               phase_d     = PH_CHAR;
               fetch_cnt_d = 4'd0;
               busy_d      = 1'b1;
               state_d     = S_FETCH;
            end
         end

         S_FETCH: begin
            if (fetch_cnt == FETCH_LAST) begin
               shreg_d    = fetch_byte;
               baud_cnt_d = 16'd0;
               tx_d       = 1'b0;
               state_d    = S_START_BIT;
            end else begin
               fetch_cnt_d = fetch_cnt + 4'd1;
            end
         end

         S_START_BIT: begin
            tx_d = 1'b0;
            if (baud_last) begin
               baud_cnt_d = 16'd0;
               bit_cnt_d  = 3'd0;
               tx_d       = shreg[0];
               state_d    = S_DATA_BITS;
            end else begin
               baud_cnt_d = baud_cnt + 16'd1;
            end
         end

         S_DATA_BITS: begin
            // shreg[0] is always the bit on the line; shift on each bit boundary.
            tx_d = shreg[0];
            if (baud_last) begin
               baud_cnt_d = 16'd0;
               if (bit_cnt == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = S_STOP_BIT;
               end else begin
                  shreg_d   = {1'b0, shreg[7:1]};
                  tx_d      = shreg[1];
                  bit_cnt_d = bit_cnt + 3'd1;
               end
            end else begin
               baud_cnt_d = baud_cnt + 16'd1;
            end
         end

         S_STOP_BIT: begin
            if (baud_last) begin
               baud_cnt_d = 16'd0;
               state_d    = S_NEXT;
            end else begin
               baud_cnt_d = baud_cnt + 16'd1;
            end
         end

         S_NEXT: begin
            fetch_cnt_d = 4'd0;
            // charIndex parks at 15 through CR/LF so it never wraps mid-dump.
            if ((charIndex != 4'd15) && (phase == PH_CHAR)) begin
               index_d = charIndex + 4'd1;
               state_d = S_FETCH;
            end else if (CRLF_EN && (phase == PH_CHAR)) begin
               phase_d = PH_CR;
               state_d = S_FETCH;
            end else if (phase == PH_CR) begin
               phase_d = PH_LF;
               state_d = S_FETCH;
            end else begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state     <= S_IDLE;
         phase     <= PH_CHAR;
         fetch_cnt <= 4'd0;
         baud_cnt  <= 16'd0;
         bit_cnt   <= 3'd0;
         shreg     <= 8'd0;
         charIndex <= 4'd0;
         uartTx    <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_d;
         phase     <= phase_d;
         fetch_cnt <= fetch_cnt_d;
         baud_cnt  <= baud_cnt_d;
         bit_cnt   <= bit_cnt_d;
         shreg     <= shreg_d;
         charIndex <= index_d;
         uartTx    <= tx_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end

endmodule
